// File: rtl/gpio_pkg.sv
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants and types for the GPIO interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_pkg;

    localparam int GPIO_NPINS     = 16;
    localparam int DEBOUNCE_CNT_W = 8;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_sel_t;

    function automatic logic edge_hit(edge_sel_t sel, logic rise, logic fall);
        return (rise & sel.rise) | (fall & sel.fall);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_debounce.sv
// ============================================================================
// Module      : gpio_debounce
// Description : Per-pin two-flop synchronizer followed by an optional
//               stable-level filter (enabled by GPIO_IRQ_DEBOUNCE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= pin;
            r_s2 <= r_s1;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam logic [DEBOUNCE_CNT_W-1:0] c_cnt_last = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                      r_stable;
    logic [DEBOUNCE_CNT_W-1:0] r_cnt;

    // The level is accepted on the edge that completes the run of differing cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stable = r_stable;
`else
    assign stable = r_s2;
`endif

endmodule

`default_nettype wire

// File: rtl/gpio_irq_ctrl.sv
// ============================================================================
// Module      : gpio_irq_ctrl
// Description : GPIO input filter with per-pin edge-select sticky interrupts.
//               Define GPIO_IRQ_DEBOUNCE_EN to include the debounce filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int NPINS           = GPIO_NPINS,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPINS-1:0] gpio_pins,
    input  logic [NPINS-1:0] irq_en,
    input  logic [NPINS-1:0] irq_rise,
    input  logic [NPINS-1:0] irq_fall,
    input  logic [NPINS-1:0] irq_clr,
    output logic [NPINS-1:0] pin_state,
    output logic [NPINS-1:0] irq_pending,
    output logic             irq
);

    logic [NPINS-1:0] w_stable;
    logic [NPINS-1:0] w_rise;
    logic [NPINS-1:0] w_fall;
    logic [NPINS-1:0] w_set;
    logic [NPINS-1:0] r_filt_prev;
    logic [NPINS-1:0] r_pending;

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        edge_sel_t w_sel;

        gpio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .pin    (gpio_pins[i]),
            .stable (w_stable[i])
        );

        assign w_sel    = '{rise: irq_rise[i], fall: irq_fall[i]};
        assign w_set[i] = irq_en[i] & edge_hit(w_sel, w_rise[i], w_fall[i]);
    end

    assign w_rise = w_stable & ~r_filt_prev;
    assign w_fall = ~w_stable & r_filt_prev;

    // A new set overrides a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_filt_prev <= '0;
            r_pending   <= '0;
        end else begin
            r_filt_prev <= w_stable;
            r_pending   <= w_set | (r_pending & ~irq_clr);
        end
    end

    assign pin_state   = w_stable;
    assign irq_pending = r_pending;
    assign irq         = |r_pending;

endmodule

`default_nettype wire

// File: tb/tb_gpio_irq_ctrl.sv
// ============================================================================
// Module      : tb_gpio_irq_ctrl
// Description : Scoreboard bench for gpio_irq_ctrl; expectations follow the
//               build's filter setting (GPIO_IRQ_DEBOUNCE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_irq_ctrl;

    localparam int NP = 16;
    localparam int N  = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int LAT = 2 + N;
`else
    localparam int LAT = 2;
`endif
    localparam int PND = LAT + 1;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic [NP-1:0] gpio_pins = '0;
    logic [NP-1:0] irq_en    = '0;
    logic [NP-1:0] irq_rise  = '0;
    logic [NP-1:0] irq_fall  = '0;
    logic [NP-1:0] irq_clr   = '0;
    logic [NP-1:0] pin_state;
    logic [NP-1:0] irq_pending;
    logic          irq;

    gpio_irq_ctrl #(
        .NPINS           (NP),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gpio_pins   (gpio_pins),
        .irq_en      (irq_en),
        .irq_rise    (irq_rise),
        .irq_fall    (irq_fall),
        .irq_clr     (irq_clr),
        .pin_state   (pin_state),
        .irq_pending (irq_pending),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        int            sig;
        logic [NP-1:0] val;
        string         name;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;

    task automatic expect_at(int at, int sig, logic [NP-1:0] val, string name);
        exp_t e;
        e.at   = at;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic expect_all(int at, logic [NP-1:0] ps, logic [NP-1:0] pd, string name);
        expect_at(at, 0, ps, {name, "_ps"});
        expect_at(at, 1, pd, {name, "_pd"});
        expect_at(at, 2, NP'(|pd), {name, "_irq"});
    endtask

    task automatic compare(exp_t e);
        logic [NP-1:0] act;
        case (e.sig)
            0:       act = pin_state;
            1:       act = irq_pending;
            default: act = {{(NP-1){1'b0}}, irq};
        endcase
        total++;
        if (act === e.val) passed++;
        else $display("FAIL %s cycle=%0d actual=%h required=%h", e.name, cyc, act, e.val);
    endtask

    always @(negedge clk) begin : monitor
        exp_t keep[$];
        keep.delete();
        foreach (sbq[i]) begin
            if (sbq[i].at == cyc) compare(sbq[i]);
            else keep.push_back(sbq[i]);
        end
        sbq = keep;
    end

    task automatic wait_neg(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all(logic [NP-1:0] ps);
        int n;
        irq_clr = '1;
        n = cyc;
        expect_all(n + 1, ps, '0, "clear_all");
        wait_neg(1);
        irq_clr = '0;
        wait_neg(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int now;
        int r;
        logic [NP-1:0] g;
        logic [NP-1:0] ps3;
        logic [NP-1:0] pd3;

        expect_all(2, '0, '0, "reset_hold");
        wait_neg(3);
        reset = 1'b1;
        wait_neg(2);

        // clean rise on pin 3
        irq_en[3] = 1'b1; irq_rise[3] = 1'b1; gpio_pins[3] = 1'b1;
        now = cyc;
        expect_at(now + LAT - 1, 0, 16'h0000, "rise_ps_early");
        expect_at(now + LAT,     0, 16'h0008, "rise_ps");
        expect_at(now + LAT,     1, 16'h0000, "rise_pd_early");
        expect_at(now + PND,     1, 16'h0008, "rise_pd");
        expect_at(now + PND,     2, 16'h0001, "rise_irq");
        wait_neg(PND + 2);

        // 3-cycle glitch on pin 5
        irq_en[5] = 1'b1; irq_rise[5] = 1'b1; gpio_pins[5] = 1'b1;
        now = cyc;
        g = (LAT == 2) ? 16'h0020 : 16'h0000;
        expect_at(now + 2, 0, 16'h0008 | g, "glitch_ps_a");
        expect_at(now + 4, 0, 16'h0008 | g, "glitch_ps_b");
        expect_at(now + 5, 0, 16'h0008,     "glitch_ps_c");
        expect_at(now + 7, 0, 16'h0008,     "glitch_ps_d");
        expect_at(now + 8, 1, 16'h0008 | g, "glitch_pd");
        wait_neg(3);
        gpio_pins[5] = 1'b0;
        wait_neg(8);
        clear_all(16'h0008);

        // falling-only select on pin 0
        irq_en[0] = 1'b1; irq_fall[0] = 1'b1; gpio_pins[0] = 1'b1;
        now = cyc;
        expect_at(now + LAT,     0, 16'h0009, "fsel_ps_hi");
        expect_at(now + PND + 1, 1, 16'h0000, "fsel_no_rise");
        wait_neg(PND + 3);
        gpio_pins[0] = 1'b0;
        now = cyc;
        expect_at(now + LAT, 0, 16'h0008, "fsel_ps_lo");
        expect_at(now + LAT, 1, 16'h0000, "fsel_pd_early");
        expect_at(now + PND, 1, 16'h0001, "fsel_pd");
        expect_at(now + PND, 2, 16'h0001, "fsel_irq");
        wait_neg(PND + 2);
        clear_all(16'h0008);

        // set/clear collision on pin 2
        irq_en[2] = 1'b1; irq_rise[2] = 1'b1; gpio_pins[2] = 1'b1;
        now = cyc;
        expect_at(now + PND, 1, 16'h0004, "coll_first");
        wait_neg(PND + 2);
        gpio_pins[2] = 1'b0;
        wait_neg(LAT + 3);
        gpio_pins[2] = 1'b1;
        now = cyc;
        expect_at(now + PND,     1, 16'h0004, "coll_set_wins");
        expect_at(now + PND + 2, 1, 16'h0004, "coll_hold");
        wait_neg(PND - 1);
        irq_clr[2] = 1'b1;
        wait_neg(1);
        irq_clr[2] = 1'b0;
        wait_neg(3);
        irq_clr[2] = 1'b1;
        now = cyc;
        expect_at(now + 1, 1, 16'h0000, "lone_clr_pd");
        expect_at(now + 1, 2, 16'h0000, "lone_clr_irq");
        wait_neg(1);
        irq_clr[2] = 1'b0;
        wait_neg(2);

        // pending on pin 3 fall, then reset mid-debounce of pin 7
        irq_fall[3] = 1'b1; gpio_pins[3] = 1'b0;
        now = cyc;
        expect_at(now + PND, 1, 16'h0008, "fall3_pd");
        wait_neg(PND + 2);
        irq_en[7] = 1'b1; irq_rise[7] = 1'b1; gpio_pins[7] = 1'b1;
        now = cyc;
        ps3 = 16'h0004 | ((LAT <= 3) ? 16'h0080 : 16'h0000);
        pd3 = 16'h0008 | ((PND <= 3) ? 16'h0080 : 16'h0000);
        expect_at(now + 3, 0, ps3, "pre_rst_ps");
        expect_at(now + 3, 1, pd3, "pre_rst_pd");
        wait_neg(3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        expect_all(now + 4, '0, '0, "rst_async");
        wait_neg(2);
        reset = 1'b1;
        r = cyc;
        expect_at(r + 1,   0, 16'h0000, "rel_ps_zero");
        expect_at(r + LAT, 0, 16'h0084, "rel_ps");
        expect_at(r + LAT, 1, 16'h0000, "rel_pd_early");
        expect_at(r + PND, 1, 16'h0084, "rel_pd");
        expect_at(r + PND, 2, 16'h0001, "rel_irq");
        wait_neg(PND + 2);
        clear_all(16'h0084);

        // single-cycle glitch on pin 1
        irq_en[1] = 1'b1; irq_rise[1] = 1'b1; gpio_pins[1] = 1'b1;
        now = cyc;
        g = (LAT == 2) ? 16'h0002 : 16'h0000;
        expect_at(now + 2, 0, 16'h0084 | g, "g1_ps");
        expect_at(now + 3, 0, 16'h0084,     "g1_ps_low");
        expect_at(now + 3, 1, g,            "g1_pd");
        expect_at(now + 8, 1, g,            "g1_pd_late");
        expect_at(now + 8, 2, NP'(|g),      "g1_irq");
        wait_neg(1);
        gpio_pins[1] = 1'b0;
        wait_neg(10);

        foreach (sbq[i]) begin
            total++;
            $display("FAIL unchecked_%s cycle=%0d actual=never_sampled required=%h",
                     sbq[i].name, sbq[i].at, sbq[i].val);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
